psum_accum_multipass: RTL and testbench



---
 rtl/psum_pkg.sv | 52 +++++
 rtl/psum_lane.sv | 75 +++++++
 rtl/psum_accum_multipass.sv | 110 +++++++++++
 tb/tb_psum_accum_multipass.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared helpers for the multi-pass partial-sum accumulator.
//   clog2     : ceiling log2 for width derivation
//   sum_dw    : width of one channel's adder-tree sum
//   acc_dw    : width of the multi-pass accumulator (never overflows)
//   sat_to_dw : clamp a wide signed value to a DATA_WIDTH range, flag clamping
package psum_pkg;

    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic              clamp;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned sum_dw(input int unsigned dec_dw, input int unsigned macro_num);
        return dec_dw + clog2(macro_num);
    endfunction

    function automatic int unsigned acc_dw(input int unsigned dec_dw, input int unsigned macro_num,
                                           input int unsigned pass_num);
        return sum_dw(dec_dw, macro_num) + clog2(pass_num) + 1;
    endfunction

    function automatic sat_res_t sat_to_dw(input logic signed [SAT_W-1:0] v, input int unsigned dw);
        sat_res_t r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = ~hi;
        if (v > hi) begin
            r.val   = hi;
            r.clamp = 1'b1;
        end else if (v < lo) begin
            r.val   = lo;
            r.clamp = 1'b1;
        end else begin
            r.val   = v;
            r.clamp = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One output channel: registered adder tree over the macros, pass accumulator
// and output saturator.
//   clk, rstn : clock, async active-low reset
//   cap       : register this beat's tree sum
//   flush     : drop the accumulator (vs / mode_in low)
//   add       : fold the registered sum into the accumulator
//   fin       : final pass, load saturated total into data_out
//   macro_in  : MACRO_NUM signed DEC_DW decoder outputs
//   data_out  : saturated result, held between final passes
//   clamp_c   : current total would clamp (only with PSUM_SAT_STAT_EN)
module psum_lane
    import psum_pkg::*;
#(
    parameter int unsigned MACRO_NUM  = 4,
    parameter int unsigned PASS_NUM   = 2,
    parameter int unsigned DEC_DW     = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                cap,
    input  logic                                flush,
    input  logic                                add,
    input  logic                                fin,
    input  logic [MACRO_NUM-1:0][DEC_DW-1:0]    macro_in,
`ifdef PSUM_SAT_STAT_EN
    output logic                                clamp_c,
`endif
    output logic [DATA_WIDTH-1:0]               data_out
);

    localparam int unsigned SUM_DW = sum_dw(DEC_DW, MACRO_NUM);
    localparam int unsigned ACC_DW = acc_dw(DEC_DW, MACRO_NUM, PASS_NUM);

    logic signed [SUM_DW-1:0] tree_sum;
    logic signed [SUM_DW-1:0] s1_sum;
    logic signed [ACC_DW-1:0] acc;
    logic signed [ACC_DW-1:0] total;
    sat_res_t                 sat_c;

    // Adder tree, accumulated total and its saturated form
    always_comb begin
        tree_sum = '0;
        for (int unsigned m = 0; m < MACRO_NUM; m++) begin
            tree_sum = tree_sum + SUM_DW'($signed(macro_in[m]));
        end
        total = acc + ACC_DW'(s1_sum);
        sat_c = sat_to_dw(SAT_W'(total), DATA_WIDTH);
    end

`ifdef PSUM_SAT_STAT_EN
    assign clamp_c = sat_c.clamp;
`endif

    // Saturated value must be a sign-extended DATA_WIDTH value and differ from the raw total only when clamped
    always_comb begin : sat_check
        assert ((sat_c.val == SAT_W'($signed(sat_c.val[DATA_WIDTH-1:0])))
                && (sat_c.clamp == (sat_c.val != SAT_W'(total))));
    end

    // Stage-1 sum, accumulator and output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_sum   <= '0;
            acc      <= '0;
            data_out <= '0;
        end else begin
            if (cap) s1_sum <= tree_sum;
            if (flush || fin) acc <= '0;
            else if (add)     acc <= total;
            if (fin) data_out <= sat_c.val[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psum_accum_multipass.sv
// Multi-pass partial-sum accumulator: sums MACRO_NUM decoder outputs per
// channel, accumulates PASS_NUM input tiles and emits saturated results.
//   clk, rstn  : clock, async active-low reset
//   mode_in    : low = reload (idle, flushed), high = calculate
//   vs         : vsync, restarts pass alignment (coincident beat is pass 0)
//   data_e     : input beat valid
//   data_in    : [CHANNEL_NUM][MACRO_NUM] signed DEC_DW decoder outputs
//   data_e_out : one-cycle strobe per completed pixel
//   data_out   : [CHANNEL_NUM] signed saturated results, held between strobes
//   sat_cnt    : saturating count of clamped channels (PSUM_SAT_STAT_EN only)
module psum_accum_multipass
    import psum_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 128,
    parameter int unsigned MACRO_NUM   = 4,
    parameter int unsigned PASS_NUM    = 2,
    parameter int unsigned DEC_DW      = 4,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             mode_in,
    input  logic                                             vs,
    input  logic                                             data_e,
    input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][DEC_DW-1:0] data_in,
`ifdef PSUM_SAT_STAT_EN
    output logic [15:0]                                      sat_cnt,
`endif
    output logic                                             data_e_out,
    output logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0]           data_out
);

    localparam int unsigned PC_W = (PASS_NUM > 1) ? clog2(PASS_NUM) : 1;

    logic [PC_W-1:0] pass_cnt;
    logic            s1_valid;
    logic            cap;
    logic            flush;
    logic            s2_go;
    logic            last;
    logic            fin;
    logic            add;

    // Pipeline control; a flush cycle discards whatever sits in stage 1
    always_comb begin
        cap   = data_e & mode_in;
        flush = vs | ~mode_in;
        s2_go = s1_valid & ~flush;
        last  = (pass_cnt == PC_W'(PASS_NUM - 1));
        fin   = s2_go & last;
        add   = s2_go & ~last;
    end

    // Shared valid pipeline and pass counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            pass_cnt   <= '0;
            data_e_out <= 1'b0;
        end else begin
            s1_valid   <= cap;
            data_e_out <= fin;
            if (flush || fin) pass_cnt <= '0;
            else if (add)     pass_cnt <= pass_cnt + PC_W'(1);
        end
    end

`ifdef PSUM_SAT_STAT_EN
    logic [CHANNEL_NUM-1:0] clamp;
    logic [31:0]            n_clamp;
    logic [31:0]            sat_sum;

    // Count clamped channels of this result and saturate the running total
    always_comb begin
        n_clamp = '0;
        for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            n_clamp = n_clamp + 32'(clamp[c]);
        end
        sat_sum = 32'(sat_cnt) + n_clamp;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      sat_cnt <= '0;
        else if (flush) sat_cnt <= '0;
        else if (fin)   sat_cnt <= (sat_sum > 32'h0000_FFFF) ? 16'hFFFF : sat_sum[15:0];
    end
`endif

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_lane
        psum_lane #(
            .MACRO_NUM  (MACRO_NUM),
            .PASS_NUM   (PASS_NUM),
            .DEC_DW     (DEC_DW),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .cap      (cap),
            .flush    (flush),
            .add      (add),
            .fin      (fin),
            .macro_in (data_in[c]),
`ifdef PSUM_SAT_STAT_EN
            .clamp_c  (clamp[c]),
`endif
            .data_out (data_out[c])
        );
    end

endmodule

// File: tb/tb_psum_accum_multipass.sv
// Bench for psum_accum_multipass: four configurations share one stimulus
// stream (defaults / PASS_NUM=1 / DATA_WIDTH=6,PASS_NUM=4 / PASS_NUM=3).
// A pixel-level model predicts strobes and results; directed literals pin it.
module tb_psum_accum_multipass;

    localparam int NI   = 4;
    localparam int CMAX = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, mode_in, vs, data_e;
    logic [127:0][3:0][3:0] data_in;
    logic e0, e1, e2, e3;
    logic [127:0][15:0] d0;
    logic [7:0][15:0]   d1;
    logic [7:0][5:0]    d2;
    logic [7:0][15:0]   d3;
`ifdef PSUM_SAT_STAT_EN
    logic [15:0] sc0, sc1, sc2, sc3;
`endif

    psum_accum_multipass u_dut (
        .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs(vs), .data_e(data_e),
        .data_in(data_in),
`ifdef PSUM_SAT_STAT_EN
        .sat_cnt(sc0),
`endif
        .data_e_out(e0), .data_out(d0));

    psum_accum_multipass #(.CHANNEL_NUM(8), .PASS_NUM(1)) u_p1 (
        .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs(vs), .data_e(data_e),
        .data_in(data_in[7:0]),
`ifdef PSUM_SAT_STAT_EN
        .sat_cnt(sc1),
`endif
        .data_e_out(e1), .data_out(d1));

    psum_accum_multipass #(.CHANNEL_NUM(8), .PASS_NUM(4), .DATA_WIDTH(6)) u_sat (
        .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs(vs), .data_e(data_e),
        .data_in(data_in[7:0]),
`ifdef PSUM_SAT_STAT_EN
        .sat_cnt(sc2),
`endif
        .data_e_out(e2), .data_out(d2));

    psum_accum_multipass #(.CHANNEL_NUM(8), .PASS_NUM(3)) u_p3 (
        .clk(clk), .rstn(rstn), .mode_in(mode_in), .vs(vs), .data_e(data_e),
        .data_in(data_in[7:0]),
`ifdef PSUM_SAT_STAT_EN
        .sat_cnt(sc3),
`endif
        .data_e_out(e3), .data_out(d3));

    int total = 0;
    int bad   = 0;

    int pn  [NI] = '{2, 1, 4, 3};
    int dwv [NI] = '{16, 16, 6, 16};
    int cn  [NI] = '{128, 8, 8, 8};

    // Pixel model: running sum of beats in the current pixel, completed pixel
    // result, and the expected registered outputs.
    longint acc_m [NI][CMAX];
    longint res_m [NI][CMAX];
    longint exp_d [NI][CMAX];
    int     cnt_m [NI];
    bit     pend_m[NI];
    bit     exp_e [NI];
    int     exp_sc[NI];
    int     scnt  [NI];

    function automatic longint beat_val(input int c);
        longint s;
        s = 0;
        for (int m = 0; m < 4; m++) s += longint'($signed(data_in[c[6:0]][m[1:0]]));
        return s;
    endfunction

    function automatic longint sat_m(input longint v, input int dw);
        longint hi, lo;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint act_d(input int i, input int c);
        case (i)
            0:       return longint'($signed(d0[c[6:0]]));
            1:       return longint'($signed(d1[c[2:0]]));
            2:       return longint'($signed(d2[c[2:0]]));
            default: return longint'($signed(d3[c[2:0]]));
        endcase
    endfunction

    function automatic bit act_e(input int i);
        case (i)
            0:       return e0;
            1:       return e1;
            2:       return e2;
            default: return e3;
        endcase
    endfunction

`ifdef PSUM_SAT_STAT_EN
    function automatic int act_sc(input int i);
        case (i)
            0:       return int'(sc0);
            1:       return int'(sc1);
            2:       return int'(sc2);
            default: return int'(sc3);
        endcase
    endfunction
`endif

    // Model update at each sampling edge / async reset
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            for (int i = 0; i < NI; i++) begin
                if (!rstn) begin
                    cnt_m[i] = 0; pend_m[i] = 0; exp_e[i] = 0; exp_sc[i] = 0;
                    for (int c = 0; c < CMAX; c++) begin
                        acc_m[i][c] = 0; res_m[i][c] = 0; exp_d[i][c] = 0;
                    end
                end else begin
                    bit flush;
                    int ncl;
                    flush = vs || !mode_in;
                    exp_e[i] = 0;
                    if (pend_m[i] && !flush) begin
                        exp_e[i] = 1;
                        ncl = 0;
                        for (int c = 0; c < cn[i]; c++) begin
                            exp_d[i][c] = sat_m(res_m[i][c], dwv[i]);
                            if (exp_d[i][c] != res_m[i][c]) ncl++;
                        end
                        exp_sc[i] = (exp_sc[i] + ncl > 65535) ? 65535 : exp_sc[i] + ncl;
                    end
                    pend_m[i] = 0;
                    if (flush) begin
                        cnt_m[i] = 0; exp_sc[i] = 0;
                        for (int c = 0; c < CMAX; c++) acc_m[i][c] = 0;
                    end
                    if (data_e && mode_in) begin
                        for (int c = 0; c < cn[i]; c++) acc_m[i][c] += beat_val(c);
                        cnt_m[i]++;
                        if (cnt_m[i] == pn[i]) begin
                            for (int c = 0; c < CMAX; c++) begin
                                res_m[i][c] = acc_m[i][c]; acc_m[i][c] = 0;
                            end
                            cnt_m[i] = 0;
                            pend_m[i] = 1;
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        for (int i = 0; i < NI; i++) scnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                int bad_c;
                if (act_e(i)) scnt[i]++;
                total++;
                if (act_e(i) !== exp_e[i]) begin
                    bad++;
                    $display("FAIL strobe inst%0d t=%0t got=%0b want=%0b", i, $time, act_e(i), exp_e[i]);
                end
                bad_c = -1;
                for (int c = 0; c < cn[i]; c++) begin
                    if (bad_c < 0 && act_d(i, c) != exp_d[i][c]) bad_c = c;
                end
                total++;
                if (bad_c >= 0) begin
                    bad++;
                    $display("FAIL data inst%0d ch%0d t=%0t got=%0d want=%0d",
                             i, bad_c, $time, act_d(i, bad_c), exp_d[i][bad_c]);
                end
`ifdef PSUM_SAT_STAT_EN
                total++;
                if (act_sc(i) != exp_sc[i]) begin
                    bad++;
                    $display("FAIL sat_cnt inst%0d t=%0t got=%0d want=%0d", i, $time, act_sc(i), exp_sc[i]);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int kind, input int v);
        for (int c = 0; c < 128; c++)
            for (int m = 0; m < 4; m++)
                data_in[c[6:0]][m[1:0]] = 4'((kind == 0) ? v : (c % 8) - 4);
    endtask

    task automatic beats(input int n, input int kind, input int v);
        for (int b = 0; b < n; b++) begin
            data_e = 1'b1;
            set_data(kind, v);
            step();
        end
        data_e = 1'b0;
    endtask

    task automatic pulse_vs();
        vs = 1'b1;
        step();
        vs = 1'b0;
    endtask

    int snap;

    initial begin
        rstn = 1'b1; mode_in = 1'b0; vs = 1'b0; data_e = 1'b0; data_in = '0;
        #1 rstn = 1'b0;
        repeat (3) step();
        check("reset_data", act_d(0, 5), 0);
        check("reset_strobe", longint'(e0), 0);
        rstn = 1'b1; mode_in = 1'b1;
        step();

        // Two beats of +1 on PASS_NUM=2: result 8, strobe two cycles after beat 2
        snap = scnt[0];
        beats(2, 0, 1);
        check("lat_cycle1", longint'(e0), 0);
        step();
        check("lat_cycle2", longint'(e0), 1);
        check("sum8_ch0", act_d(0, 0), 8);
        check("sum8_ch127", act_d(0, 127), 8);
        step();
        check("lat_cycle3", longint'(e0), 0);
        check("one_strobe", longint'(scnt[0] - snap), 1);
        check("p1_unit", act_d(1, 3), 4);
        pulse_vs();

        // PASS_NUM=1, 10 back-to-back beats of c%8-4
        snap = scnt[1];
        beats(10, 1, 0);
        step(); step();
        check("p1_ten", longint'(scnt[1] - snap), 10);
        for (int c = 0; c < 8; c++) check("p1_pattern", act_d(1, c), 4 * ((c % 8) - 4));
        pulse_vs();

        // Saturation on DATA_WIDTH=6, PASS_NUM=4
        beats(4, 0, 7);
        step(); step();
        check("sat_hi", act_d(2, 0), 31);
        check("sat_hi_ch7", act_d(2, 7), 31);
`ifdef PSUM_SAT_STAT_EN
        check("sat_cnt_hi", longint'(sc2), 8);
`endif
        pulse_vs();
        beats(4, 0, -8);
        step(); step();
        check("sat_lo", act_d(2, 3), -32);
`ifdef PSUM_SAT_STAT_EN
        check("sat_cnt_lo", longint'(sc2), 8);
`endif
        pulse_vs();

        // PASS_NUM=3: beat, vs with beat, two beats -> sum of last three only
        snap = scnt[3];
        beats(1, 0, 5);
        vs = 1'b1;
        beats(1, 0, 1);
        vs = 1'b0;
        beats(1, 0, 2);
        beats(1, 0, 3);
        step(); step();
        check("vs_one_strobe", longint'(scnt[3] - snap), 1);
        check("vs_sum", act_d(3, 2), 24);
        pulse_vs();

        // mode_in low mid-pixel: output held, pre-drop beat discarded
        beats(2, 0, 3);
        step(); step();
        check("pre_drop", act_d(0, 0), 24);
        beats(1, 0, 7);
        mode_in = 1'b0;
        data_e = 1'b1;
        set_data(0, 7);
        for (int k = 0; k < 5; k++) begin
            step();
            check("low_hold", act_d(0, 0), 24);
            check("low_no_strobe", longint'(e0), 0);
        end
        data_e = 1'b0;
        mode_in = 1'b1;
        beats(2, 0, 2);
        step(); step();
        check("after_mode", act_d(0, 0), 16);

        // Reset one cycle after a final-pass beat: no strobe, outputs zero
        beats(2, 0, 1);
        rstn = 1'b0;
        snap = scnt[0];
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_no_strobe", longint'(e0), 0);
            check("rst_zero", act_d(0, 64), 0);
        end
        check("rst_cnt", longint'(scnt[0] - snap), 0);
        rstn = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
